// File: rtl/cmd_sequencer_if.sv
// Merged-word stream from the timing scheduler into the command sequencer.
interface cmd_sequencer_if #(
  parameter int MERGED_WIDTH = 640
);
  logic [MERGED_WIDTH-1:0] S_AXIS_TDATA;
  logic                    S_AXIS_TVALID;
  logic                    S_AXIS_TREADY;

  modport master (output S_AXIS_TDATA, output S_AXIS_TVALID, input  S_AXIS_TREADY);
  modport slave  (input  S_AXIS_TDATA, input  S_AXIS_TVALID, output S_AXIS_TREADY);
endinterface

// File: rtl/cmd_sequencer.sv
// Latches one merged word and plays its four command slots onto the PHY,
// honouring each slot's idle-cycle delay; back-to-back words without a bubble.
module cmd_sequencer #(
  parameter int INSTR_WIDTH  = 128,
  parameter int WDATA_WIDTH  = 512,
  parameter int MERGED_WIDTH = INSTR_WIDTH + WDATA_WIDTH,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cmd_sequencer_if.slave         s_axis,
  output logic                   phy_cmd_valid,
  output logic [2:0]             phy_cmd_op,
  output logic [2:0]             phy_cmd_bank,
  output logic [16:0]            phy_cmd_addr,
  output logic [WDATA_WIDTH-1:0] phy_wdata,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   issued_count
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_WR  = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             slot_q, slot_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [WDATA_WIDTH-1:0] wdata_q;

  logic [MERGED_WIDTH-1:0] word;
  logic [3:0][31:0]        slots;
  logic [31:0]             cur;
  logic [2:0]              cur_op;
  logic [8:0]              cur_dly;
  logic                    in_issue, last_cycle, ready, hs, load;

  assign word  = s_axis.S_AXIS_TDATA;
  assign slots = instr_q;
  assign cur     = slots[slot_q];
  assign cur_op  = cur[2:0];
  assign cur_dly = cur[31:23];

  assign in_issue   = (state_q == ISSUE);
  // Final cycle of a word: the sequencer can accept the next one right here.
  assign last_cycle = (slot_q == 2'd3) &&
                      ((in_issue && cur_dly == 9'd0) ||
                       (state_q == WAIT && cnt_q == 9'd1));
  assign ready = rst_n && ((state_q == IDLE) || last_cycle);
  assign hs    = s_axis.S_AXIS_TVALID && ready;
  assign s_axis.S_AXIS_TREADY = ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: ;
      ISSUE: begin
        if (cur_dly != 9'd0) begin
          state_d = WAIT;
          cnt_d   = cur_dly;
        end else if (slot_q != 2'd3) begin
          slot_d = slot_q + 2'd1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1 && slot_q != 2'd3) begin
          state_d = ISSUE;
          slot_d  = slot_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (last_cycle)
      state_d = IDLE;
    if (hs) begin
      load    = 1'b1;
      slot_d  = 2'd0;
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= 2'd0;
      cnt_q        <= 9'd0;
      instr_q      <= '0;
      wdata_q      <= '0;
      issued_count <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      issued_count <= issued_count + {{(CNT_WIDTH-1){1'b0}}, phy_cmd_valid};
      if (load) begin
        instr_q <= word[INSTR_WIDTH-1:0];
        wdata_q <= word[MERGED_WIDTH-1:INSTR_WIDTH];
      end
    end
  end

  // PHY side is purely a decode of the held slot; silent outside ISSUE.
  always_comb begin
    phy_cmd_valid = 1'b0;
    phy_cmd_op    = 3'd0;
    phy_cmd_bank  = 3'd0;
    phy_cmd_addr  = 17'd0;
    phy_wdata     = '0;
    if (in_issue) begin
      phy_cmd_valid = (cur_op != OP_NOP);
      phy_cmd_op    = cur_op;
      phy_cmd_bank  = cur[5:3];
      phy_cmd_addr  = cur[22:6];
      if (cur_op == OP_WR)
        phy_wdata = wdata_q;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
Downstream consumer of the timing scheduler's 640-bit merged stream (instruction [127:0], write data [639:128]). It latches one merged word at a time and issues its four 32-bit command slots to the PHY command interface in order, slot 0 first. After each slot it inserts that slot's programmed idle-cycle delay. The DRAM command timing is therefore fixed by the instruction encoding, and the PHY applies no backpressure.

Parameters:
INSTR_WIDTH, 128, instruction portion width (4 slots x 32 bits).
WDATA_WIDTH, 512, write-data portion width.
MERGED_WIDTH, 640, INSTR_WIDTH + WDATA_WIDTH.
CNT_WIDTH, 32, width of the issued-command counter.

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
S_AXIS_TDATA  in  MERGED_WIDTH  merged word from the timing scheduler.
S_AXIS_TVALID  in  1  merged word valid.
S_AXIS_TREADY  out  1  sequencer can take a word this cycle.
phy_cmd_valid  out  1  a command is presented this cycle.
phy_cmd_op  out  3  opcode.
phy_cmd_bank  out  3  bank.
phy_cmd_addr  out  17  row/column address.
phy_wdata  out  WDATA_WIDTH  write data; nonzero only on WR.
busy  out  1  a word is held (state is not IDLE).
issued_count  out  CNT_WIDTH  total commands issued.

Behaviour:
- Reset is asynchronous, active-low (rst_n). While rst_n=0:
  - state=IDLE, slot=0, delay counter=0, held word cleared, issued_count=0.
  - All outputs 0, including S_AXIS_TREADY.
  - Reset mid-word abandons the word; no further slots are issued.
- Slot layout (slot k = instr[32k+31:32k]):
  - [2:0] op: 0=NOP, 1=ACT, 2=PRE, 3=RD, 4=WR, 5=REF, 6/7=reserved (issued as-is).
  - [5:3] bank; [22:6] addr; [31:23] delay D (0..511).
- States:
  - IDLE: S_AXIS_TREADY=1. A handshake latches the word, sets slot=0 and moves to ISSUE.
  - ISSUE: lasts exactly one cycle per slot.
    - Outputs decode the held word at the current slot.
    - phy_cmd_valid = (op != 0); a NOP slot still consumes this cycle and its delay.
    - phy_wdata = held wdata when op==WR, else 0. All WR slots in a word share the same wdata.
    - If D != 0: go to WAIT with cnt=D.
    - Else if slot < 3: slot+1, stay in ISSUE.
    - Else: the word is done.
  - WAIT: all phy outputs 0; cnt decrements each cycle.
    - The cycle with cnt==1 is the last wait cycle.
    - After it: go to ISSUE with slot+1, or finish the word if slot==3.
- Timing:
  - Handshake in cycle N puts slot 0 on the PHY in cycle N+1.
  - Consecutive slots are separated by exactly D idle cycles (spacing D+1).
- Word completion and back-to-back:
  - S_AXIS_TREADY is also 1 in the word's final cycle: (ISSUE, slot 3, D==0) or (WAIT, slot 3, cnt==1).
  - A handshake in that cycle latches the new word, sets slot=0 and enters ISSUE next cycle, with no bubble.
  - With no handshake in that cycle: go to IDLE.
  - S_AXIS_TREADY is 0 in every other cycle; TDATA is not sampled without a handshake.
- Outputs:
  - phy_* outputs are combinational from registered state, word and slot, and are 0 outside ISSUE.
  - busy = (state != IDLE).
- issued_count increments by 1 on every cycle with phy_cmd_valid=1. It wraps modulo 2^CNT_WIDTH with no saturation.
- Max per-word duration is 4 + 4*511 cycles. The counter never underflows, because WAIT is entered only with D ≥ 1.

Test Plan:
- Reset: hold rst_n=0 with TVALID=1 -> TREADY=0, phy_cmd_valid=0, issued_count=0. After release, TREADY=1 and no handshake occurs before the first rising edge with rst_n=1.
- Word with slots ACT(bank2, D=3), WR(D=0), RD(D=1), PRE(D=0) and wdata=0xA5..A5, handshake at cycle 0 -> commands issue as follows:
  - ACT at cycle 1, WR at 5 with phy_wdata=0xA5..A5, RD at 6, PRE at 8.
  - phy_wdata=0 on every non-WR cycle; issued_count=4.
- Two words, all slots RD with D=0, TVALID held high -> 8 RD commands on consecutive cycles 1..8. TREADY=1 only at cycles 0 and 4; busy stays high through cycle 8.
- Word of four NOPs with D=0 -> no phy_cmd_valid; busy for 4 cycles; issued_count unchanged.
- rst_n asserted 2 cycles into a D=10 WAIT -> all outputs go to 0 immediately (asynchronously); the remaining slots are never issued; after release, state is IDLE.
- Preload issued_count=0xFFFFFFFF (force), then issue 1 command -> issued_count=0.
